// File: rtl/serial_adder_pkg.sv
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared constants and types for the bit-serial adder.
//             Holds the FSM state encoding and the default operand width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    // Default operand / sum width.
    localparam int DEFAULT_WIDTH = 8;

    // State encoding constants.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } sa_state_e;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
//  Module   : serial_adder_if
//  Purpose  : Request/result bundle for serial_adder.
//             master : drives start/a/b/cin(/sub), observes busy/done/sum/cout
//             slave  : the adder side
//  Config   : SERIAL_ADDER_SUB_EN adds the 1-bit 'sub' request field.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface : serial_adder_if

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// ============================================================================
//  Module   : full_adder_v2
//  Purpose  : 1-bit full adder cell (combinational).
//  Ports    : a_i, b_i, cin_i -> sum_o, cout_o
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_v2 (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic cin_i,
    output logic      sum_o,
    output logic      cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : full_adder_v2

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder. One bit pair per clock, LSB first,
//             through a single full_adder_v2 with the carry held in a flop.
//             {cout,sum} = a + b + cin; result appears WIDTH cycles after the
//             start-sampling edge with a one-cycle done pulse.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - serial_adder_if.slave (start/a/b/cin[/sub] in,
//                      busy/done/sum/cout out, all outputs registered)
//  Config   : SERIAL_ADDER_SUB_EN - adds 'sub'; sub=1 computes a-b
//             (b inverted, carry forced to 1, cout=1 means no borrow).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_adder_if.slave   bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sa_state_e         state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  s_sh_q, s_sh_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fa_sum;
    logic              fa_cout;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

    // Operand B and initial carry as loaded on an accepted start.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    full_adder_v2 u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            // DONE accepts a new start exactly like IDLE (back-to-back).
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts the first
                // (LSB) sum bit has reached bit 0.
                s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state so that
        // busy/done come straight off flops.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule : serial_adder

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing 1-bit full adder cell. It sits directly upstream of `full_adder_v2` and drives it one bit pair per clock, LSB first, feeding the carry back through a flip-flop. It collects the sum bits into a result register. It trades latency for area and is the multi-bit front end for the team's adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when not busy.
- `a`  in  WIDTH  operand A, captured on accepted start.
- `b`  in  WIDTH  operand B, captured on accepted start.
- `cin`  in  1  carry-in, captured on accepted start.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  single-cycle completion pulse.
- `sum`  out  WIDTH  registered result.
- `cout`  out  1  registered final carry.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load `a_sh`←a, `b_sh`←b, `carry`←cin, `cnt`←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Full adder inputs are `a_sh[0]`, `b_sh[0]` and `carry`.
  - Adder sum bit shifts into the MSB of `s_sh`; `a_sh` and `b_sh` shift right.
  - `carry` ← adder cout; `cnt`++.
  - On the cycle where `cnt`==WIDTH-1: `sum` ← final `s_sh` value including this bit, `cout` ← adder cout; go to DONE.
- DONE, one cycle:
  - `done`=1.
  - start=1 here is accepted exactly as in IDLE and goes to RUN (back-to-back operation). Otherwise go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- `sum`/`cout` hold their last result until the next completion. They never show partial values.
- start while in RUN is ignored; inputs a, b, cin are don't-care after capture.
- Reset (any time, including mid-RUN):
  - State goes to IDLE.
  - `busy`, `done`, `sum`, `cout` and all internal registers go to 0.
  - The operation in progress is discarded.

## Timing
- Edge E0 samples start: `busy`=1 from after E0. `busy`=1 exactly in RUN; `busy`=0 in IDLE and DONE.
- Edges E1..E(WIDTH) each process one bit. `sum`/`cout` update at E(WIDTH).
- `done` is high for the one cycle between E(WIDTH) and E(WIDTH+1).
- Latency from start-sample edge to `done` rising is WIDTH cycles.
- Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Adds input port `sub` (1 bit), captured on accepted start.
  - sub=1 loads `b_sh`←~b and `carry`←1, with cin ignored. The result is a−b. `cout`=1 means no borrow.
  - sub=0 behaves identically to the undefined case.
- `SERIAL_ADDER_SUB_EN` undefined: no `sub` port; add only.

## Structure
- A shared package `serial_adder_pkg` holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- One sub-module: a single instance of the existing `full_adder_v2` performs the per-bit add. No other arithmetic is inferred.
- Counter width is $clog2(WIDTH).

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, start one cycle:
  - `busy` is high for 8 cycles.
  - `done` pulses once.
  - sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start held high continuously with a new operand pair each accept:
  - Results arrive every 9 cycles.
  - A start pulse issued during RUN is ignored and produces no extra `done`.
- Assert rst_n=0 on the 3rd RUN cycle → all outputs 0, state IDLE. A new start then completes correctly.
- With `SERIAL_ADDER_SUB_EN`:
  - a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0.
  - a=0x07, b=0x05, sub=1 → sum=0x02, cout=1.
- Random a, b, cin (≥1000 operations) compared against reference a+b+cin. `sum` is stable between `done` pulses.
